// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one 4-bit CLA group resolved per stage,
// operands skewed in and results deskewed out so every field of a transaction emerges together.
module cla_pipe_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf,
   output logic             pg,
   output logic             gg
);

   localparam int L   = WIDTH / 4;
   localparam int MSB = WIDTH - 1;

   // {carry-out, sum[3:0]} of a 4-bit group with every internal carry in lookahead form
   function automatic logic [4:0] cla4_sum(input logic [3:0] x, input logic [3:0] y,
                                           input logic cin);
      logic [3:0] p;
      logic [3:0] g;
      logic [4:0] c;
      p    = x ^ y;
      g    = x & y;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (&p & cin);
      return {c[4], p ^ c[3:0]};
   endfunction

   function automatic logic [1:0] cla4_gp(input logic [3:0] x, input logic [3:0] y);
      logic [3:0] p;
      logic [3:0] g;
      p = x ^ y;
      g = x & y;
      return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p};
   endfunction

   logic             adv;
   logic [L-1:0]     vld_q;
   logic [WIDTH-1:0] a_q    [0:L-1];
   logic [WIDTH-1:0] bp_q   [0:L-1];
   logic [WIDTH-1:0] s_q    [0:L-1];
   logic             c_q    [0:L-1];
   logic             pacc_q [0:L-1];
   logic             gacc_q [0:L-1];

   logic [WIDTH-1:0] s_d    [0:L-1];
   logic             c_d    [0:L-1];
   logic             pacc_d [0:L-1];
   logic             gacc_d [0:L-1];
   logic             ovf_d;

   logic             out_valid_q;
   logic [WIDTH-1:0] sum_q;
   logic             co_q;
   logic             ovf_q;
   logic             pg_q;
   logic             gg_q;

   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign co        = co_q;
   assign ovf       = ovf_q;
   assign pg        = pg_q;
   assign gg        = gg_q;

   // stage k resolves group k from the carry and group P/G accumulated by stages below it
   always_comb begin
      for (int k = 0; k < L; k++) begin
         logic [4:0] grp;
         logic [1:0] gp;
         grp                = cla4_sum(a_q[k][4*k +: 4], bp_q[k][4*k +: 4], c_q[k]);
         gp                 = cla4_gp(a_q[k][4*k +: 4], bp_q[k][4*k +: 4]);
         s_d[k]             = s_q[k];
         s_d[k][4*k +: 4]   = grp[3:0];
         c_d[k]             = grp[4];
         pacc_d[k]          = gp[0] & pacc_q[k];
         gacc_d[k]          = gp[1] | (gp[0] & gacc_q[k]);
      end
      ovf_d = (a_q[L-1][MSB] == bp_q[L-1][MSB]) && (s_d[L-1][MSB] != a_q[L-1][MSB]);
   end

   // stage 0 captures the effective operands; later stages shift the skew/deskew data
   always_ff @(posedge clk) begin
      if (adv) begin
         a_q[0]    <= a;
         bp_q[0]   <= sub ? ~b : b;
         c_q[0]    <= sub ? 1'b1 : ci;
         s_q[0]    <= '0;
         pacc_q[0] <= 1'b1;
         gacc_q[0] <= 1'b0;
         for (int k = 0; k < L - 1; k++) begin
            a_q[k+1]    <= a_q[k];
            bp_q[k+1]   <= bp_q[k];
            s_q[k+1]    <= s_d[k];
            c_q[k+1]    <= c_d[k];
            pacc_q[k+1] <= pacc_d[k];
            gacc_q[k+1] <= gacc_d[k];
         end
      end
   end

   // valid chain and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q       <= '0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         co_q        <= 1'b0;
         ovf_q       <= 1'b0;
         pg_q        <= 1'b0;
         gg_q        <= 1'b0;
      end else if (adv) begin
         vld_q       <= {vld_q[L-2:0], in_valid};
         out_valid_q <= vld_q[L-1];
         sum_q       <= s_d[L-1];
         co_q        <= c_d[L-1];
         ovf_q       <= ovf_d;
         pg_q        <= pacc_d[L-1];
         gg_q        <= gacc_d[L-1];
      end
   end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder (WIDTH=16): arithmetic reference model with in-order scoreboard,
// directed literal vectors, stall, mid-flight reset and randomized back-pressure.
module tb_cla_pipe_adder;

   localparam int W = 16;
   localparam int L = W / 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ci;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         co;
   logic         ovf;
   logic         pg;
   logic         gg;

   typedef struct packed {
      logic [W+3:0] mdl;
      logic         has_lit;
      logic [W+3:0] lit;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         e;
   int           n_chk = 0;
   int           n_fail = 0;
   logic         lit_en = 1'b0;
   logic [W+3:0] lit_v = '0;
   logic         hold = 1'b0;
   logic [W+3:0] hsnap = '0;
   logic         rnd_en = 1'b0;

   cla_pipe_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .co        (co),
      .ovf       (ovf),
      .pg        (pg),
      .gg        (gg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference: {sum, co, ovf, pg, gg} from plain integer arithmetic
   function automatic logic [W+3:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mci, input logic msub);
      logic [W-1:0] bp;
      logic         c0;
      logic [W:0]   full;
      logic [W:0]   nocin;
      logic         mo;
      bp    = msub ? ~mb : mb;
      c0    = msub ? 1'b1 : mci;
      full  = {1'b0, ma} + {1'b0, bp} + {{W{1'b0}}, c0};
      nocin = {1'b0, ma} + {1'b0, bp};
      mo    = (ma[W-1] == bp[W-1]) && (full[W-1] != ma[W-1]);
      return {full[W-1:0], full[W], mo, &(ma ^ bp), nocin[W]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [W+3:0] dut_out();
      return {sum, co, ovf, pg, gg};
   endfunction

   // scoreboard: everything sampled mid-cycle, transfers take effect on the following rising edge
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         hold = 1'b0;
      end else begin
         if (hold) chk("hold_stable", 64'({out_valid, dut_out()}), 64'({1'b1, hsnap}));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_output: got %h, expected no result at %0t",
                        dut_out(), $time);
            end else begin
               e = exp_q.pop_front();
               chk("result", 64'(dut_out()), 64'(e.mdl));
               if (e.has_lit) begin
                  chk("literal_dut", 64'(dut_out()), 64'(e.lit));
                  chk("literal_model", 64'(e.mdl), 64'(e.lit));
               end
            end
         end
         hold  = out_valid && !out_ready;
         hsnap = dut_out();
         if (in_valid && in_ready)
            exp_q.push_back('{mdl: model(a, b, ci, sub), has_lit: lit_en, lit: lit_v});
      end
   end

   always @(posedge clk) begin
      if (rnd_en) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci,
                       input logic tsub, input logic le, input logic [W+3:0] lv);
      int   n;
      logic ok;
      a        = ta;
      b        = tb;
      ci       = tci;
      sub      = tsub;
      lit_en   = le;
      lit_v    = lv;
      in_valid = 1'b1;
      n        = 0;
      do begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 500);
      if (!ok) chk("accept_timeout", 64'(ok), 64'(1));
      in_valid = 1'b0;
      lit_en   = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic measure_latency(input string name);
      int cyc;
      cyc = 0;
      while (!out_valid && cyc < 50) begin
         tick();
         cyc++;
      end
      chk(name, 64'(cyc), 64'(L));
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk(name, 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      int   n;
      logic [W+3:0] snap;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      ci        = 1'b0;
      sub       = 1'b0;
      #2;
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_fields", 64'(dut_out()), 64'(0));
      chk("reset_in_ready", 64'(in_ready), 64'(1));
      tick();
      tick();
      rst_n = 1'b1;

      // latency and directed literal vectors: {sum, co, ovf, pg, gg}
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1});
      measure_latency("latency_first");
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b0});
      send(16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
      send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, {16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0});
      send(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, {16'h0002, 1'b1, 1'b0, 1'b0, 1'b1});
      send(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, {16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1});
      drain("drain_directed");

      // six back-to-back transactions with a three-cycle output stall
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(16'(16'h1111 * (i + 1)), 16'(16'h0F0F + i * 16'h0101), i[0], i[1],
                    1'b0, '0);
         end
         begin
            n = 0;
            while (!out_valid && n < 100) begin
               tick();
               n++;
            end
            out_ready = 1'b0;
            snap      = dut_out();
            repeat (3) begin
               @(negedge clk);
               chk("stall_in_ready", 64'(in_ready), 64'(0));
               chk("stall_out_valid", 64'(out_valid), 64'(1));
               chk("stall_fields", 64'(dut_out()), 64'(snap));
               tick();
            end
            out_ready = 1'b1;
         end
      join
      drain("drain_stall");

      // reset pulse with two transactions in flight, first one already at the output
      out_ready = 1'b0;
      send(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, '0);
      send(16'h9999, 16'h1111, 1'b0, 1'b1, 1'b0, '0);
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      chk("pre_reset_valid", 64'(out_valid), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("reset_async_valid", 64'(out_valid), 64'(0));
      chk("reset_async_fields", 64'(dut_out()), 64'(0));
      chk("reset_in_ready", 64'(in_ready), 64'(1));
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("post_reset_idle", 64'(out_valid), 64'(0));
      end
      send(16'h0100, 16'h00FF, 1'b1, 1'b0, 1'b1, {16'h0200, 1'b0, 1'b0, 1'b0, 1'b0});
      measure_latency("latency_after_reset");
      drain("drain_reset");

      // random operands, random bubbles, random back-pressure
      rnd_en = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 4) == 0) tick();
         send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0);
      end
      rnd_en = 1'b0;
      tick();
      out_ready = 1'b1;
      drain("drain_random");

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, %0d vectors applied", n_chk);
      $fatal(1, "watchdog expired");
   end

endmodule
